load_buffer: RTL and testbench

- Parametrised, multi-entry successor to the per-FU load queue.
- Holds up to DEPTH in-flight loads whose address and store-forward lookup are already resolved.
- Issues non-forwarded loads to the dcache over DC_PORTS request channels and accepts tagged miss responses.
- Presents completed, aligned and extended results to up to CDB_PORTS CDB slots. Supports full squash with epoch tagging so stale dcache responses are dropped.

---
 rtl/load_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_load_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer.sv
// load_buffer: multi-entry load buffer sitting between address/forwarding
// resolution and the CDB. Loads that were not forwarded from the store queue
// are issued to the dcache; miss responses come back tagged with
// {epoch, entry index} so that responses belonging to squashed loads are
// recognised and dropped.
module load_buffer #(
  parameter  int DEPTH      = 8,
  parameter  int IN_PORTS   = 2,
  parameter  int DC_PORTS   = 1,
  parameter  int RESP_PORTS = 2,
  parameter  int CDB_PORTS  = 2,
  parameter  int PRN_W      = 6,
  parameter  int ROBN_W     = 5,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int TAG_W      = IDX_W + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [IN_PORTS-1:0]               alloc_valid,
  input  logic [IN_PORTS-1:0][31:0]         alloc_addr,
  input  logic [IN_PORTS-1:0][2:0]          alloc_func,
  input  logic [IN_PORTS-1:0][PRN_W-1:0]    alloc_prn,
  input  logic [IN_PORTS-1:0][ROBN_W-1:0]   alloc_robn,
  input  logic [IN_PORTS-1:0]               alloc_fwd_valid,
  input  logic [IN_PORTS-1:0][31:0]         alloc_fwd_data,
  output logic [IN_PORTS-1:0]               alloc_ready,
  output logic [IDX_W:0]                    free_count,
  output logic [DC_PORTS-1:0]               dc_req_valid,
  output logic [DC_PORTS-1:0][31:0]         dc_req_addr,
  output logic [DC_PORTS-1:0][2:0]          dc_req_func,
  output logic [DC_PORTS-1:0][TAG_W-1:0]    dc_req_tag,
  input  logic [DC_PORTS-1:0]               dc_req_accept,
  input  logic [DC_PORTS-1:0]               dc_req_data_valid,
  input  logic [DC_PORTS-1:0][31:0]         dc_req_data,
  input  logic [RESP_PORTS-1:0]             dc_resp_valid,
  input  logic [RESP_PORTS-1:0][TAG_W-1:0]  dc_resp_tag,
  input  logic [RESP_PORTS-1:0][31:0]       dc_resp_data,
  output logic [CDB_PORTS-1:0]              cdb_prepared,
  output logic [CDB_PORTS-1:0][ROBN_W-1:0]  cdb_robn,
  output logic [CDB_PORTS-1:0][PRN_W-1:0]   cdb_prn,
  output logic [CDB_PORTS-1:0][31:0]        cdb_result,
  input  logic [CDB_PORTS-1:0]              cdb_selected
);

  typedef enum logic [1:0] {FREE, NO_FWD, ASKED, KNOWN} state_e;

  state_e              state_q [DEPTH];
  state_e              state_d [DEPTH];
  logic [31:0]         addr_q  [DEPTH];
  logic [31:0]         addr_d  [DEPTH];
  logic [2:0]          func_q  [DEPTH];
  logic [2:0]          func_d  [DEPTH];
  logic [PRN_W-1:0]    prn_q   [DEPTH];
  logic [PRN_W-1:0]    prn_d   [DEPTH];
  logic [ROBN_W-1:0]   robn_q  [DEPTH];
  logic [ROBN_W-1:0]   robn_d  [DEPTH];
  logic [31:0]         data_q  [DEPTH];
  logic [31:0]         data_d  [DEPTH];
  logic                epoch_q;
  logic                epoch_d;

  logic [IN_PORTS-1:0]             alloc_hit;
  logic [IN_PORTS-1:0][IDX_W-1:0]  alloc_idx;
  logic [DEPTH-1:0]                alloc_taken;
  logic [DC_PORTS-1:0]             dc_sel_vld;
  logic [DC_PORTS-1:0][IDX_W-1:0]  dc_sel_idx;
  logic [DEPTH-1:0]                dc_taken;
  logic [CDB_PORTS-1:0]            cdb_sel_vld;
  logic [CDB_PORTS-1:0][IDX_W-1:0] cdb_sel_idx;
  logic [DEPTH-1:0]                cdb_taken;

  // Shift the byte/half into place, then zero- or sign-extend by func[2].
  function automatic logic [31:0] align_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  func);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (func[1:0])
      2'd0:    return func[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return func[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Count FREE entries in registered state; drives allocation readiness.
  always_comb begin
    free_count = '0;
    for (int i = 0; i < DEPTH; i++)
      if (state_q[i] == FREE) free_count = free_count + (IDX_W+1)'(1);
  end

  // Port k may allocate only if more than k entries are free.
  always_comb begin
    for (int k = 0; k < IN_PORTS; k++)
      alloc_ready[k] = (free_count > (IDX_W+1)'(k));
  end

  // Give each accepted allocation port the lowest FREE entry not yet taken.
  always_comb begin
    alloc_hit   = '0;
    alloc_idx   = '0;
    alloc_taken = '0;
    for (int k = 0; k < IN_PORTS; k++) begin
      if (alloc_valid[k] && alloc_ready[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!alloc_hit[k] && state_q[i] == FREE && !alloc_taken[i]) begin
            alloc_hit[k]   = 1'b1;
            alloc_idx[k]   = IDX_W'(i);
            alloc_taken[i] = 1'b1;
          end
        end
      end
    end
  end

  // Pick NO_FWD entries, lowest index first, for the dcache request ports.
  always_comb begin
    dc_sel_vld = '0;
    dc_sel_idx = '0;
    dc_taken   = '0;
    for (int p = 0; p < DC_PORTS; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!dc_sel_vld[p] && state_q[i] == NO_FWD && !dc_taken[i]) begin
          dc_sel_vld[p] = 1'b1;
          dc_sel_idx[p] = IDX_W'(i);
          dc_taken[i]   = 1'b1;
        end
      end
    end
  end

  // Pick KNOWN entries, lowest index first, for the CDB slots.
  always_comb begin
    cdb_sel_vld = '0;
    cdb_sel_idx = '0;
    cdb_taken   = '0;
    for (int s = 0; s < CDB_PORTS; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!cdb_sel_vld[s] && state_q[i] == KNOWN && !cdb_taken[i]) begin
          cdb_sel_vld[s] = 1'b1;
          cdb_sel_idx[s] = IDX_W'(i);
          cdb_taken[i]   = 1'b1;
        end
      end
    end
  end

  // Drive dcache request ports; squash suppresses any issue this cycle.
  always_comb begin
    for (int p = 0; p < DC_PORTS; p++) begin
      dc_req_valid[p] = dc_sel_vld[p] & ~squash;
      dc_req_addr[p]  = '0;
      dc_req_func[p]  = '0;
      dc_req_tag[p]   = '0;
      if (dc_req_valid[p]) begin
        dc_req_addr[p] = addr_q[dc_sel_idx[p]];
        dc_req_func[p] = func_q[dc_sel_idx[p]];
        dc_req_tag[p]  = {epoch_q, dc_sel_idx[p]};
      end
    end
  end

  // Drive CDB slots with the aligned, extended result of the chosen entry.
  always_comb begin
    for (int s = 0; s < CDB_PORTS; s++) begin
      cdb_prepared[s] = cdb_sel_vld[s] & ~squash;
      cdb_robn[s]     = '0;
      cdb_prn[s]      = '0;
      cdb_result[s]   = '0;
      if (cdb_prepared[s]) begin
        cdb_robn[s]   = robn_q[cdb_sel_idx[s]];
        cdb_prn[s]    = prn_q[cdb_sel_idx[s]];
        cdb_result[s] = align_extend(data_q[cdb_sel_idx[s]],
                                     addr_q[cdb_sel_idx[s]][1:0],
                                     func_q[cdb_sel_idx[s]]);
      end
    end
  end

  // Entry next-state: squash clears everything and flips the epoch;
  // otherwise apply allocation, dcache issue, miss response and CDB release.
  always_comb begin
    epoch_d = epoch_q;
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      func_d[i]  = func_q[i];
      prn_d[i]   = prn_q[i];
      robn_d[i]  = robn_q[i];
      data_d[i]  = data_q[i];
    end
    if (squash) begin
      epoch_d = ~epoch_q;
      for (int i = 0; i < DEPTH; i++) state_d[i] = FREE;
    end else begin
      for (int k = 0; k < IN_PORTS; k++) begin
        if (alloc_hit[k]) begin
          state_d[alloc_idx[k]] = alloc_fwd_valid[k] ? KNOWN : NO_FWD;
          addr_d[alloc_idx[k]]  = alloc_addr[k];
          func_d[alloc_idx[k]]  = alloc_func[k];
          prn_d[alloc_idx[k]]   = alloc_prn[k];
          robn_d[alloc_idx[k]]  = alloc_robn[k];
          data_d[alloc_idx[k]]  = alloc_fwd_data[k];
        end
      end
      for (int p = 0; p < DC_PORTS; p++) begin
        if (dc_req_valid[p] && dc_req_accept[p]) begin
          if (dc_req_data_valid[p]) begin
            state_d[dc_sel_idx[p]] = KNOWN;
            data_d[dc_sel_idx[p]]  = dc_req_data[p];
          end else begin
            state_d[dc_sel_idx[p]] = ASKED;
          end
        end
      end
      for (int r = 0; r < RESP_PORTS; r++) begin
        if (dc_resp_valid[r] && dc_resp_tag[r][TAG_W-1] == epoch_q &&
            state_q[dc_resp_tag[r][IDX_W-1:0]] == ASKED) begin
          state_d[dc_resp_tag[r][IDX_W-1:0]] = KNOWN;
          data_d[dc_resp_tag[r][IDX_W-1:0]]  = dc_resp_data[r];
        end
      end
      for (int s = 0; s < CDB_PORTS; s++) begin
        if (cdb_prepared[s] && cdb_selected[s]) state_d[cdb_sel_idx[s]] = FREE;
      end
    end
  end

  // Entry registers and epoch bit, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epoch_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= FREE;
        addr_q[i]  <= '0;
        func_q[i]  <= '0;
        prn_q[i]   <= '0;
        robn_q[i]  <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      epoch_q <= epoch_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i]  <= addr_d[i];
        func_q[i]  <= func_d[i];
        prn_q[i]   <= prn_d[i];
        robn_q[i]  <= robn_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Testbench for load_buffer with default parameters (DEPTH=8, 2 alloc ports,
// 1 dcache port, 2 response ports, 2 CDB slots).
module tb_load_buffer;

  localparam int DEPTH = 8, IN_PORTS = 2, DC_PORTS = 1, RESP_PORTS = 2;
  localparam int CDB_PORTS = 2, PRN_W = 6, ROBN_W = 5, IDX_W = 3, TAG_W = 4;

  logic                              clock = 1'b0;
  logic                              reset = 1'b1;
  logic                              squash;
  logic [IN_PORTS-1:0]               alloc_valid;
  logic [IN_PORTS-1:0][31:0]         alloc_addr;
  logic [IN_PORTS-1:0][2:0]          alloc_func;
  logic [IN_PORTS-1:0][PRN_W-1:0]    alloc_prn;
  logic [IN_PORTS-1:0][ROBN_W-1:0]   alloc_robn;
  logic [IN_PORTS-1:0]               alloc_fwd_valid;
  logic [IN_PORTS-1:0][31:0]         alloc_fwd_data;
  logic [IN_PORTS-1:0]               alloc_ready;
  logic [IDX_W:0]                    free_count;
  logic [DC_PORTS-1:0]               dc_req_valid;
  logic [DC_PORTS-1:0][31:0]         dc_req_addr;
  logic [DC_PORTS-1:0][2:0]          dc_req_func;
  logic [DC_PORTS-1:0][TAG_W-1:0]    dc_req_tag;
  logic [DC_PORTS-1:0]               dc_req_accept;
  logic [DC_PORTS-1:0]               dc_req_data_valid;
  logic [DC_PORTS-1:0][31:0]         dc_req_data;
  logic [RESP_PORTS-1:0]             dc_resp_valid;
  logic [RESP_PORTS-1:0][TAG_W-1:0]  dc_resp_tag;
  logic [RESP_PORTS-1:0][31:0]       dc_resp_data;
  logic [CDB_PORTS-1:0]              cdb_prepared;
  logic [CDB_PORTS-1:0][ROBN_W-1:0]  cdb_robn;
  logic [CDB_PORTS-1:0][PRN_W-1:0]   cdb_prn;
  logic [CDB_PORTS-1:0][31:0]        cdb_result;
  logic [CDB_PORTS-1:0]              cdb_selected;

  int n_checks = 0;
  int n_fail   = 0;
  int drops    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  func;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  load_buffer dut (
    .clock(clock), .reset(reset), .squash(squash),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_func(alloc_func),
    .alloc_prn(alloc_prn), .alloc_robn(alloc_robn),
    .alloc_fwd_valid(alloc_fwd_valid), .alloc_fwd_data(alloc_fwd_data),
    .alloc_ready(alloc_ready), .free_count(free_count),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_func(dc_req_func), .dc_req_tag(dc_req_tag),
    .dc_req_accept(dc_req_accept), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data(dc_req_data),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag),
    .dc_resp_data(dc_resp_data),
    .cdb_prepared(cdb_prepared), .cdb_robn(cdb_robn), .cdb_prn(cdb_prn),
    .cdb_result(cdb_result), .cdb_selected(cdb_selected)
  );

  always #5 clock = ~clock;

  // Count allocation requests made while the port was not ready.
  always @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < IN_PORTS; k++)
        if (alloc_valid[k] && !alloc_ready[k]) drops <= drops + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    squash = 0; alloc_valid = '0; alloc_addr = '0; alloc_func = '0;
    alloc_prn = '0; alloc_robn = '0; alloc_fwd_valid = '0; alloc_fwd_data = '0;
    dc_req_accept = '0; dc_req_data_valid = '0; dc_req_data = '0;
    dc_resp_valid = '0; dc_resp_tag = '0; dc_resp_data = '0; cdb_selected = '0;
  endtask

  task automatic alloc(input int k, input logic [31:0] addr, input logic [2:0] func,
                       input logic fwd, input logic [31:0] data,
                       input logic [PRN_W-1:0] prn, input logic [ROBN_W-1:0] robn);
    alloc_valid[k] = 1'b1; alloc_addr[k] = addr; alloc_func[k] = func;
    alloc_fwd_valid[k] = fwd; alloc_fwd_data[k] = data;
    alloc_prn[k] = prn; alloc_robn[k] = robn;
  endtask

  initial begin
    vecs[0] = '{32'h1003, 3'd0, 32'h80000000, 32'hFFFFFF80};
    vecs[1] = '{32'h1000, 3'd0, 32'h0000007F, 32'h0000007F};
    vecs[2] = '{32'h1001, 3'd4, 32'h0000A500, 32'h000000A5};
    vecs[3] = '{32'h1002, 3'd0, 32'h00F00000, 32'hFFFFFFF0};
    vecs[4] = '{32'h1000, 3'd1, 32'h00008001, 32'hFFFF8001};
    vecs[5] = '{32'h1002, 3'd5, 32'hBEEF1234, 32'h0000BEEF};
    vecs[6] = '{32'h1003, 3'd2, 32'h12345678, 32'h12345678};
    vecs[7] = '{32'h1002, 3'd1, 32'h7FFF0000, 32'h00007FFF};
    vecs[8] = '{32'h1001, 3'd5, 32'h00ABCD00, 32'h0000ABCD};

    clear_inputs();
    #1;
    // Reset state
    check("rst_free_count", 32'(free_count), 32'd8);
    check("rst_alloc_ready", 32'(alloc_ready), 32'h3);
    check("rst_dc_req_valid", 32'(dc_req_valid), 32'h0);
    check("rst_cdb_prepared", 32'(cdb_prepared), 32'h0);
    check("rst_cdb_result0", cdb_result[0], 32'h0);
    check("rst_dc_req_tag", 32'(dc_req_tag), 32'h0);
    repeat (2) @(posedge clock);
    #3 reset = 0;
    step();

    // Forwarded loads: alignment and extension across sizes and offsets
    for (int v = 0; v < 9; v++) begin
      alloc(0, vecs[v].addr, vecs[v].func, 1'b1, vecs[v].word, PRN_W'(v + 1), ROBN_W'(v + 3));
      step();
      alloc_valid = '0;
      check($sformatf("vec%0d_prepared", v), 32'(cdb_prepared), 32'h1);
      check($sformatf("vec%0d_result", v), cdb_result[0], vecs[v].exp);
      check($sformatf("vec%0d_prn", v), 32'(cdb_prn[0]), 32'(v + 1));
      check($sformatf("vec%0d_robn", v), 32'(cdb_robn[0]), 32'(v + 3));
      cdb_selected[0] = 1'b1;
      step();
      cdb_selected = '0;
      check($sformatf("vec%0d_freed", v), 32'(free_count), 32'd8);
      check($sformatf("vec%0d_cdb_idle", v), 32'(cdb_prepared), 32'h0);
    end

    // Dcache hit returned with the accept
    alloc(0, 32'h2002, 3'd5, 1'b0, 32'h0, 6'd9, 5'd9);
    step();
    alloc_valid = '0;
    check("hit_req_valid", 32'(dc_req_valid), 32'h1);
    check("hit_req_addr", dc_req_addr[0], 32'h2002);
    check("hit_req_func", 32'(dc_req_func[0]), 32'h5);
    check("hit_req_tag", 32'(dc_req_tag[0]), 32'h0);
    check("hit_not_prepared", 32'(cdb_prepared), 32'h0);
    dc_req_accept = 1'b1; dc_req_data_valid = 1'b1; dc_req_data = 32'hBEEF1234;
    step();
    dc_req_accept = '0; dc_req_data_valid = '0;
    check("hit_req_idle", 32'(dc_req_valid), 32'h0);
    check("hit_prepared", 32'(cdb_prepared), 32'h1);
    check("hit_result", cdb_result[0], 32'h0000BEEF);
    cdb_selected[0] = 1'b1;
    step();
    cdb_selected = '0;
    check("hit_freed", 32'(free_count), 32'd8);

    // Two misses with out-of-order responses
    alloc(0, 32'h3000, 3'd2, 1'b0, 32'h0, 6'd1, 5'd1);
    alloc(1, 32'h3004, 3'd2, 1'b0, 32'h0, 6'd2, 5'd2);
    step();
    alloc_valid = '0;
    check("miss_free_count", 32'(free_count), 32'd6);
    check("miss_req0_tag", 32'(dc_req_tag[0]), 32'h0);
    dc_req_accept = 1'b1;
    step();
    check("miss_req1_valid", 32'(dc_req_valid), 32'h1);
    check("miss_req1_tag", 32'(dc_req_tag[0]), 32'h1);
    step();
    dc_req_accept = '0;
    check("miss_req_idle", 32'(dc_req_valid), 32'h0);
    check("miss_asked_no_cdb", 32'(cdb_prepared), 32'h0);
    dc_resp_valid[0] = 1'b1; dc_resp_tag[0] = 4'h1; dc_resp_data[0] = 32'h11;
    step();
    dc_resp_valid = '0;
    check("miss_one_prepared", 32'(cdb_prepared), 32'h1);
    check("miss_one_result", cdb_result[0], 32'h11);
    dc_resp_valid[1] = 1'b1; dc_resp_tag[1] = 4'h0; dc_resp_data[1] = 32'h22;
    step();
    dc_resp_valid = '0;
    check("miss_both_prepared", 32'(cdb_prepared), 32'h3);
    check("miss_slot0_result", cdb_result[0], 32'h22);
    check("miss_slot1_result", cdb_result[1], 32'h11);
    check("miss_slot1_robn", 32'(cdb_robn[1]), 32'd2);
    cdb_selected = 2'b11;
    step();
    cdb_selected = '0;
    check("miss_freed", 32'(free_count), 32'd8);

    // Fill all entries with the dcache stalled
    alloc(0, 32'h4000, 3'd2, 1'b1, 32'hAAAA0000, 6'd0, 5'd0);
    alloc(1, 32'h4004, 3'd2, 1'b0, 32'h0, 6'd1, 5'd1);
    step();
    for (int c = 0; c < 3; c++) begin
      alloc(0, 32'h4100 + 32'(8 * c), 3'd2, 1'b0, 32'h0, 6'd2, 5'd2);
      alloc(1, 32'h4104 + 32'(8 * c), 3'd2, 1'b0, 32'h0, 6'd3, 5'd3);
      step();
    end
    alloc_valid = '0;
    check("full_free_count", 32'(free_count), 32'd0);
    check("full_alloc_ready", 32'(alloc_ready), 32'h0);
    check("full_drain_prepared", 32'(cdb_prepared), 32'h1);
    alloc(0, 32'h4F00, 3'd2, 1'b1, 32'h0, 6'd5, 5'd5);
    step();
    alloc_valid = '0;
    check("full_drop", 32'(free_count), 32'd0);
    cdb_selected[0] = 1'b1;
    step();
    cdb_selected = '0;
    check("full_release_ready", 32'(alloc_ready), 32'h1);
    check("full_release_count", 32'(free_count), 32'd1);

    // Squash with an outstanding miss, then a stale response
    check("sq_pre_req_valid", 32'(dc_req_valid), 32'h1);
    check("sq_pre_req_tag", 32'(dc_req_tag[0]), 32'h1);
    dc_req_accept = 1'b1;
    step();
    dc_req_accept = '0;
    check("sq_pre_next_tag", 32'(dc_req_tag[0]), 32'h2);
    squash = 1'b1;
    alloc(0, 32'h5F00, 3'd2, 1'b1, 32'h0, 6'd7, 5'd7);
    dc_req_accept = 1'b1;
    dc_resp_valid[0] = 1'b1; dc_resp_tag[0] = 4'h1; dc_resp_data[0] = 32'h99;
    #1;
    check("sq_req_gated", 32'(dc_req_valid), 32'h0);
    check("sq_cdb_gated", 32'(cdb_prepared), 32'h0);
    step();
    clear_inputs();
    check("sq_free_count", 32'(free_count), 32'd8);
    check("sq_cdb_idle", 32'(cdb_prepared), 32'h0);
    alloc(0, 32'h5000, 3'd2, 1'b0, 32'h0, 6'd4, 5'd4);
    step();
    alloc_valid = '0;
    check("ep1_req_tag", 32'(dc_req_tag[0]), 32'h8);
    dc_req_accept = 1'b1;
    step();
    dc_req_accept = '0;
    dc_resp_valid[0] = 1'b1; dc_resp_tag[0] = 4'h0; dc_resp_data[0] = 32'h77;
    step();
    dc_resp_valid = '0;
    check("ep1_stale_dropped", 32'(cdb_prepared), 32'h0);
    check("ep1_stale_count", 32'(free_count), 32'd7);
    dc_resp_valid[1] = 1'b1; dc_resp_tag[1] = 4'h8; dc_resp_data[1] = 32'h55;
    step();
    dc_resp_valid = '0;
    check("ep1_resp_prepared", 32'(cdb_prepared), 32'h1);
    check("ep1_resp_result", cdb_result[0], 32'h55);
    cdb_selected[0] = 1'b1;
    step();
    cdb_selected = '0;

    // Asynchronous reset between clock edges
    alloc(0, 32'h6000, 3'd2, 1'b1, 32'h1, 6'd1, 5'd1);
    alloc(1, 32'h6004, 3'd2, 1'b1, 32'h2, 6'd2, 5'd2);
    step();
    alloc_valid = '0;
    alloc(0, 32'h6008, 3'd2, 1'b1, 32'h3, 6'd3, 5'd3);
    step();
    alloc_valid = '0;
    check("ar_pre_count", 32'(free_count), 32'd5);
    check("ar_pre_prepared", 32'(cdb_prepared), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("ar_prepared", 32'(cdb_prepared), 32'h0);
    check("ar_free_count", 32'(free_count), 32'd8);
    check("ar_alloc_ready", 32'(alloc_ready), 32'h3);
    #3 reset = 1'b0;
    step();
    check("ar_post_count", 32'(free_count), 32'd8);

    check("dropped_allocs", 32'(drops), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
